// File: rtl/seg_text_render_if.sv
// Pixel-path bundle for seg_text_render: scan coordinates, glyph buffer writes,
// blink controls and the registered lit-pixel result.
interface seg_text_render_if #(
  parameter int NUM_CHARS = 4
);
  logic [9:0]           start_x;
  logic [9:0]           start_y;
  logic [9:0]           x;
  logic [9:0]           y;
  logic                 frame_tick;
  logic                 wr_en;
  logic [3:0]           wr_addr;
  logic [3:0]           wr_code;
  logic [NUM_CHARS-1:0] blink_mask;
  logic                 display;

  modport master (
    output start_x, start_y, x, y, frame_tick, wr_en, wr_addr, wr_code, blink_mask,
    input  display
  );

  modport slave (
    input  start_x, start_y, x, y, frame_tick, wr_en, wr_addr, wr_code, blink_mask,
    output display
  );
endinterface

// File: rtl/seg_text_render.sv
// Two-stage pipelined renderer for a row of seven-segment glyphs held in a small
// writable buffer, with integer scaling and per-character frame-tick blinking.
module seg_text_render #(
  parameter int NUM_CHARS    = 4,
  parameter int SCALE_SHIFT  = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  seg_text_render_if.slave  bus
);

  localparam int          CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [12:0] BOX_W = 13'((NUM_CHARS * 32) << SCALE_SHIFT);
  localparam logic [12:0] BOX_H = 13'(40 << SCALE_SHIFT);
  localparam logic [3:0]  CODE_BLANK = 4'hF;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_t;

  function automatic seg_t glyph_segs(input logic [3:0] code);
    case (code)
      4'd0:    glyph_segs = seg_t'(7'b1111110);
      4'd1:    glyph_segs = seg_t'(7'b0110000);
      4'd2:    glyph_segs = seg_t'(7'b1101101);
      4'd3:    glyph_segs = seg_t'(7'b1111001);
      4'd4:    glyph_segs = seg_t'(7'b0110011);
      4'd5:    glyph_segs = seg_t'(7'b1011011);
      4'd6:    glyph_segs = seg_t'(7'b1011111);
      4'd7:    glyph_segs = seg_t'(7'b1110000);
      4'd8:    glyph_segs = seg_t'(7'b1111111);
      4'd9:    glyph_segs = seg_t'(7'b1111011);
      4'd10:   glyph_segs = seg_t'(7'b1100111);
      4'd11:   glyph_segs = seg_t'(7'b0001110);
      4'd12:   glyph_segs = seg_t'(7'b1110111);
      4'd13:   glyph_segs = seg_t'(7'b1001111);
      4'd14:   glyph_segs = seg_t'(7'b0000001);
      default: glyph_segs = seg_t'(7'b0000000);
    endcase
  endfunction

  // Segment rectangles in unscaled cell coordinates; columns 26..31 never match.
  function automatic logic seg_hit(input seg_t s, input logic [4:0] lx, input logic [5:0] ly);
    logic col_mid;
    logic col_left;
    logic col_right;
    col_mid   = (lx >= 5'd5)  && (lx <= 5'd20);
    col_left  = (lx <= 5'd4);
    col_right = (lx >= 5'd21) && (lx <= 5'd25);
    seg_hit = (s.a && col_mid   && (ly <= 6'd4))
           || (s.g && col_mid   && (ly >= 6'd17) && (ly <= 6'd21))
           || (s.d && col_mid   && (ly >= 6'd35) && (ly <= 6'd39))
           || (s.f && col_left  && (ly >= 6'd5)  && (ly <= 6'd16))
           || (s.b && col_right && (ly >= 6'd5)  && (ly <= 6'd16))
           || (s.e && col_left  && (ly >= 6'd22) && (ly <= 6'd34))
           || (s.c && col_right && (ly >= 6'd22) && (ly <= 6'd34));
  endfunction

  // Offsets are 11-bit two's complement so a scan left of or above the box goes negative instead of wrapping.
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_box;
  logic [3:0]  w_char;
  logic [4:0]  w_lx;
  logic [5:0]  w_ly;

  assign w_dx     = {1'b0, bus.x} - {1'b0, bus.start_x};
  assign w_dy     = {1'b0, bus.y} - {1'b0, bus.start_y};
  assign w_in_box = !w_dx[10] && !w_dy[10]
                 && ({2'b00, w_dx} < BOX_W) && ({2'b00, w_dy} < BOX_H);
  assign w_char   = 4'(w_dx >> (5 + SCALE_SHIFT));
  assign w_lx     = w_dx[4 + SCALE_SHIFT -: 5];
  assign w_ly     = 6'(w_dy >> SCALE_SHIFT);

  logic       r_in_box;
  logic [3:0] r_char;
  logic [4:0] r_lx;
  logic [5:0] r_ly;

  // NOTE: clocked state always uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_box <= 1'b0;
      r_char   <= 4'd0;
      r_lx     <= 5'd0;
      r_ly     <= 6'd0;
    end else begin
      r_in_box <= w_in_box;
      r_char   <= w_char;
      r_lx     <= w_lx;
      r_ly     <= w_ly;
    end
  end

  logic [3:0] r_buf [NUM_CHARS];

  // NOTE: the glyph buffer is a handful of flops rather than a RAM, so it takes the reset to blank like any register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_buf[i] <= CODE_BLANK;
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (bus.wr_addr == 4'(i)) begin
          r_buf[i] <= bus.wr_code;
        end
      end
    end
  end

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (bus.frame_tick) begin
      if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  logic [3:0] w_code;
  logic       w_blink_en;
  seg_t       w_segs;
  logic       w_lit;

  // NOTE: every combinational output gets a default first so no path can leave it holding a value (no latch).
  always_comb begin
    w_code     = CODE_BLANK;
    w_blink_en = 1'b0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (r_char == 4'(i)) begin
        w_code     = r_buf[i];
        w_blink_en = bus.blink_mask[i];
      end
    end
  end

  assign w_segs = glyph_segs(w_code);
  assign w_lit  = r_in_box && seg_hit(w_segs, r_lx, r_ly) && !(r_blink_phase && w_blink_en);

  logic r_display;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_display <= 1'b0;
    end else begin
      r_display <= w_lit;
    end
  end

  assign bus.display = r_display;

endmodule

// File: tb/tb_seg_text_render.sv
// Scoreboard bench for seg_text_render: two instances (unscaled with fast blink,
// and 2x scaled), expected pixels queued at drive time and compared at output time.
module tb_seg_text_render;

  localparam int NC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  int    q_due[$];
  bit    q_exp[$];
  int    q_dut[$];
  string q_tag[$];

  seg_text_render_if #(.NUM_CHARS(NC)) bus_a ();
  seg_text_render_if #(.NUM_CHARS(NC)) bus_b ();

  seg_text_render #(.NUM_CHARS(NC), .SCALE_SHIFT(0), .BLINK_FRAMES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  seg_text_render #(.NUM_CHARS(NC), .SCALE_SHIFT(1), .BLINK_FRAMES(30)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output for stimulus driven after edge E appears after edge E+2.
  always @(negedge clk) begin : monitor
    logic got;
    while (q_due.size() > 0 && q_due[0] <= edge_cnt) begin
      got = (q_dut[0] == 0) ? bus_a.display : bus_b.display;
      check(q_tag[0], {31'd0, got}, {31'd0, q_exp[0]});
      void'(q_due.pop_front());
      void'(q_exp.pop_front());
      void'(q_dut.pop_front());
      void'(q_tag.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int dut, input int px, input int py, input bit exp, input string tag);
    if (dut == 0) begin
      bus_a.x = 10'(px);
      bus_a.y = 10'(py);
    end else begin
      bus_b.x = 10'(px);
      bus_b.y = 10'(py);
    end
    q_due.push_back(edge_cnt + 2);
    q_exp.push_back(exp);
    q_dut.push_back(dut);
    q_tag.push_back(tag);
    tick();
  endtask

  task automatic write_glyph(input int dut, input int addr, input int code);
    if (dut == 0) begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'(addr); bus_a.wr_code = 4'(code);
    end else begin
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'(addr); bus_b.wr_code = 4'(code);
    end
    tick();
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  task automatic set_start(input int dut, input int sx, input int sy);
    if (dut == 0) begin
      bus_a.start_x = 10'(sx); bus_a.start_y = 10'(sy);
    end else begin
      bus_b.start_x = 10'(sx); bus_b.start_y = 10'(sy);
    end
  endtask

  int t2_tab [9][3] = '{
    '{105, 50, 1}, '{100, 50, 0}, '{126, 60, 0}, '{121, 60, 1}, '{110, 60, 0},
    '{100, 60, 1}, '{110, 69, 1}, '{110, 87, 1}, '{104, 54, 0}
  };

  // Buffer {1,2,3,4} at start (100,50); also probes that a write to address 7 changed nothing.
  int t3_tab [11][3] = '{
    '{153, 60, 1}, '{99, 60, 0},  '{228, 60, 0}, '{105, 50, 0}, '{121, 60, 1},
    '{132, 75, 1}, '{153, 75, 0}, '{164, 75, 0}, '{169, 50, 1}, '{201, 50, 0},
    '{217, 60, 1}
  };

  int t4_tab [5][3] = '{
    '{10, 34, 1}, '{41, 43, 1}, '{10, 33, 0}, '{42, 34, 0}, '{9, 34, 0}
  };

  initial begin
    bus_a.start_x = '0; bus_a.start_y = '0; bus_a.x = '0; bus_a.y = '0;
    bus_a.frame_tick = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_code = '0;
    bus_a.blink_mask = '0;
    bus_b.start_x = '0; bus_b.start_y = '0; bus_b.x = '0; bus_b.y = '0;
    bus_b.frame_tick = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_code = '0;
    bus_b.blink_mask = '0;

    // T1: reset held three cycles, then a blank buffer renders nothing anywhere.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_display_a", {31'd0, bus_a.display}, 32'd0);
      check("rst_display_b", {31'd0, bus_b.display}, 32'd0);
    end
    reset = 1'b0;
    set_start(0, 100, 50);
    set_start(1, 100, 50);
    for (int yy = 50; yy < 90; yy += 13) begin
      for (int xx = 96; xx < 232; xx += 9) begin
        pix(0, xx, yy, 1'b0, "t1_blank_a");
      end
    end
    pix(1, 110, 84, 1'b0, "t1_blank_b");
    pix(1, 142, 60, 1'b0, "t1_blank_b");

    // T2: digit 8 at char 0.
    write_glyph(0, 0, 8);
    for (int i = 0; i < 9; i++) begin
      pix(0, t2_tab[i][0], t2_tab[i][1], bit'(t2_tab[i][2]), $sformatf("t2_pix%0d", i));
    end

    // T3: indexing, bounds, no wrap, and an out-of-range write.
    write_glyph(0, 0, 1);
    write_glyph(0, 1, 2);
    write_glyph(0, 2, 3);
    write_glyph(0, 3, 4);
    for (int i = 0; i < 3; i++) begin
      pix(0, t3_tab[i][0], t3_tab[i][1], bit'(t3_tab[i][2]), $sformatf("t3_pix%0d", i));
    end
    set_start(0, 1000, 50);
    pix(0, 5, 60, 1'b0, "t3_nowrap_5");
    pix(0, 997, 60, 1'b0, "t3_nowrap_997");
    set_start(0, 100, 50);
    write_glyph(0, 7, 8);
    for (int i = 3; i < 11; i++) begin
      pix(0, t3_tab[i][0], t3_tab[i][1], bit'(t3_tab[i][2]), $sformatf("t3_pix%0d", i));
    end

    // T4: 2x scale, '-' at char 0, box at the origin.
    write_glyph(1, 0, 14);
    set_start(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      pix(1, t4_tab[i][0], t4_tab[i][1], bit'(t4_tab[i][2]), $sformatf("t4_pix%0d", i));
    end

    // T5: blink every 2 ticks on char 0 only; char 1 is never masked.
    write_glyph(0, 0, 8);
    write_glyph(0, 1, 8);
    set_start(0, 0, 0);
    bus_a.blink_mask = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      pix(0, 5, 0, ((k / 2) % 2) == 0, $sformatf("t5_blink_after%0d", k));
      pix(0, 37, 0, 1'b1, $sformatf("t5_steady_after%0d", k));
      bus_a.frame_tick = 1'b1;
      tick();
      bus_a.frame_tick = 1'b0;
    end
    bus_a.blink_mask = 4'b0000;
    tick();

    // T6: write under a held seg-a pixel, then reset mid-stream.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_start(0, 0, 0);
    bus_a.x = 10'd5;
    bus_a.y = 10'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle", {31'd0, bus_a.display}, 32'd0);
    end
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd0; bus_a.wr_code = 4'd8;
    tick();
    bus_a.wr_en = 1'b0;
    check("t6_write_edge", {31'd0, bus_a.display}, 32'd0);
    tick();
    check("t6_first_lit", {31'd0, bus_a.display}, 32'd1);
    tick();
    check("t6_hold_lit", {31'd0, bus_a.display}, 32'd1);
    reset = 1'b1;
    tick();
    check("t6_reset_edge", {31'd0, bus_a.display}, 32'd0);
    reset = 1'b0;
    tick();
    check("t6_after_release", {31'd0, bus_a.display}, 32'd0);
    tick();
    check("t6_buffer_cleared", {31'd0, bus_a.display}, 32'd0);

    repeat (4) tick();
    check("sb_drain", q_due.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
